// File: rtl/mlp_seq_pkg.sv
// Shared types and constants for the MLP layer sequencer: FSM state encoding,
// buffer select encodings and the default network shape.
package mlp_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_DATA,
      ST_MM,
      ST_ACT,
      ST_ARGMAX,
      ST_DONE
   } seq_state_e;

   localparam logic [1:0] SRC_INPUT = 2'd0;
   localparam logic [1:0] SRC_BUF_A = 2'd1;
   localparam logic [1:0] SRC_BUF_B = 2'd2;

   localparam logic DST_BUF_A = 1'b0;
   localparam logic DST_BUF_B = 1'b1;

   // Field 0 (lowest bits) is the input length, field i the output length of layer i.
   localparam logic [49:0] DEF_LAYER_DIMS = {10'd10, 10'd32, 10'd64, 10'd64, 10'd784};
   localparam logic [3:0]  DEF_RELU_MASK  = 4'b0111;

   // Layer 0 reads the input vector; later layers read what the previous layer wrote.
   function automatic logic [1:0] src_sel_for(input logic [2:0] layer);
      if (layer == 3'd0) return SRC_INPUT;
      return layer[0] ? SRC_BUF_A : SRC_BUF_B;
   endfunction

   function automatic logic dst_sel_for(input logic [2:0] layer);
      return layer[0] ? DST_BUF_B : DST_BUF_A;
   endfunction

endpackage

// File: rtl/mlp_seq_watchdog.sv
// Per-operation stall timer: down-counter reloaded on every engine start,
// flags expiry when it reaches terminal count while an operation is pending.
module mlp_seq_watchdog #(
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic clk,
   input  logic resetn,
   input  logic clear,
   input  logic active,
   output logic expire
);

   localparam int               CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                         cnt_q <= '0;
      else if (clear)                      cnt_q <= RELOAD;
      else if (active && (cnt_q != '0))    cnt_q <= cnt_q - CNT_W'(1);
   end

   assign expire = active && !clear && (cnt_q == '0);

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Data-driven N-layer FC sequencer driving shared matmul, ReLU and argmax engines.
// Optional stall watchdog enabled by defining MLP_SEQ_WATCHDOG_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for start
// WAIT_DATA  | run accepted, waiting for the input vector (in_ready)
// MM         | matmul of layer layer_idx in flight
// ACT        | in-place ReLU on the buffer layer_idx just wrote
// ARGMAX     | classification over the final logits
// DONE       | one-cycle completion pulse, result valid
module mlp_layer_sequencer
   import mlp_seq_pkg::*;
#(
   parameter int                               NUM_LAYERS     = 4,
   parameter int                               DIM_W          = 10,
   parameter logic [(NUM_LAYERS+1)*DIM_W-1:0]  LAYER_DIMS     = DEF_LAYER_DIMS,
   parameter logic [NUM_LAYERS-1:0]            RELU_MASK      = DEF_RELU_MASK,
   parameter int                               IDX_W          = 4,
   parameter int                               TIMEOUT_CYCLES = 1048576
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             abort,
   input  logic             in_ready,
   output logic             mm_start,
   output logic [DIM_W-1:0] mm_k,
   output logic [DIM_W-1:0] mm_n,
   output logic [1:0]       mm_src_sel,
   output logic             mm_dst_sel,
   input  logic             mm_done,
   output logic             act_start,
   output logic [DIM_W-1:0] act_d,
   output logic             act_buf_sel,
   input  logic             act_done,
   output logic             am_start,
   output logic [DIM_W-1:0] am_size,
   output logic             am_buf_sel,
   input  logic             am_done,
   input  logic [IDX_W-1:0] am_index,
   output logic             busy,
   output logic             done,
   output logic [IDX_W-1:0] result,
   output logic [2:0]       layer_idx,
   output logic             error
);

   localparam logic [2:0] LAST_LAYER = 3'(NUM_LAYERS - 1);

   function automatic logic [DIM_W-1:0] dim_field(input int idx);
      logic [(NUM_LAYERS+1)*DIM_W-1:0] shifted;
      shifted = LAYER_DIMS >> (idx * DIM_W);
      return shifted[DIM_W-1:0];
   endfunction

   function automatic logic relu_en(input int idx);
      logic [NUM_LAYERS-1:0] shifted;
      shifted = RELU_MASK >> idx;
      return shifted[0];
   endfunction

   seq_state_e       state_q, state_nxt;
   logic             mm_start_nxt, act_start_nxt, am_start_nxt;
   logic [DIM_W-1:0] mm_k_nxt, mm_n_nxt, act_d_nxt, am_size_nxt;
   logic [1:0]       mm_src_sel_nxt;
   logic             mm_dst_sel_nxt, act_buf_sel_nxt, am_buf_sel_nxt;
   logic             busy_nxt, done_nxt;
   logic [IDX_W-1:0] result_nxt;
   logic [2:0]       layer_nxt;
   logic             issue_mm, advance;
   logic             wd_expire;

`ifdef MLP_SEQ_WATCHDOG_EN
   logic error_nxt;
   logic wd_active;

   assign wd_active = (state_q == ST_MM) || (state_q == ST_ACT) || (state_q == ST_ARGMAX);

   mlp_seq_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .resetn (resetn),
      .clear  (mm_start | act_start | am_start),
      .active (wd_active),
      .expire (wd_expire)
   );
`else
   assign wd_expire = 1'b0;
   assign error     = 1'b0;
`endif

   always_comb begin
      state_nxt       = state_q;
      layer_nxt       = layer_idx;
      mm_start_nxt    = 1'b0;
      act_start_nxt   = 1'b0;
      am_start_nxt    = 1'b0;
      mm_k_nxt        = mm_k;
      mm_n_nxt        = mm_n;
      mm_src_sel_nxt  = mm_src_sel;
      mm_dst_sel_nxt  = mm_dst_sel;
      act_d_nxt       = act_d;
      act_buf_sel_nxt = act_buf_sel;
      am_size_nxt     = am_size;
      am_buf_sel_nxt  = am_buf_sel;
      result_nxt      = result;
      issue_mm        = 1'b0;
      advance         = 1'b0;
`ifdef MLP_SEQ_WATCHDOG_EN
      error_nxt       = error;
`endif

      // A done pulse coinciding with its own start pulse belongs to a previous operation.
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_WAIT_DATA;
               layer_nxt = 3'd0;
`ifdef MLP_SEQ_WATCHDOG_EN
               error_nxt = 1'b0;
`endif
            end
         end
         ST_WAIT_DATA: begin
            if (in_ready) issue_mm = 1'b1;
         end
         ST_MM: begin
            if (mm_done && !mm_start) begin
               if (relu_en(int'(layer_idx))) begin
                  state_nxt       = ST_ACT;
                  act_start_nxt   = 1'b1;
                  act_buf_sel_nxt = layer_idx[0];
                  act_d_nxt       = dim_field(int'(layer_idx) + 1);
               end else begin
                  advance = 1'b1;
               end
            end
         end
         ST_ACT: begin
            if (act_done && !act_start) advance = 1'b1;
         end
         ST_ARGMAX: begin
            if (am_done && !am_start) begin
               state_nxt  = ST_DONE;
               result_nxt = am_index;
            end
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase

      if (advance) begin
         if (layer_idx < LAST_LAYER) begin
            layer_nxt = layer_idx + 3'd1;
            issue_mm  = 1'b1;
         end else begin
            state_nxt      = ST_ARGMAX;
            am_start_nxt   = 1'b1;
            am_buf_sel_nxt = LAST_LAYER[0];
            am_size_nxt    = dim_field(NUM_LAYERS);
         end
      end

      if (issue_mm) begin
         state_nxt      = ST_MM;
         mm_start_nxt   = 1'b1;
         mm_k_nxt       = dim_field(int'(layer_nxt));
         mm_n_nxt       = dim_field(int'(layer_nxt) + 1);
         mm_src_sel_nxt = src_sel_for(layer_nxt);
         mm_dst_sel_nxt = dst_sel_for(layer_nxt);
      end

      if (abort) begin
         state_nxt     = ST_IDLE;
         layer_nxt     = layer_idx;
         mm_start_nxt  = 1'b0;
         act_start_nxt = 1'b0;
         am_start_nxt  = 1'b0;
         result_nxt    = result;
`ifdef MLP_SEQ_WATCHDOG_EN
         error_nxt     = error;
`endif
      end

      if (wd_expire) begin
         state_nxt     = ST_IDLE;
         mm_start_nxt  = 1'b0;
         act_start_nxt = 1'b0;
         am_start_nxt  = 1'b0;
`ifdef MLP_SEQ_WATCHDOG_EN
         error_nxt     = 1'b1;
`endif
      end

      busy_nxt = (state_nxt != ST_IDLE);
      done_nxt = (state_nxt == ST_DONE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         layer_idx   <= '0;
         mm_start    <= 1'b0;
         act_start   <= 1'b0;
         am_start    <= 1'b0;
         mm_k        <= '0;
         mm_n        <= '0;
         mm_src_sel  <= '0;
         mm_dst_sel  <= 1'b0;
         act_d       <= '0;
         act_buf_sel <= 1'b0;
         am_size     <= '0;
         am_buf_sel  <= 1'b0;
         result      <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         layer_idx   <= layer_nxt;
         mm_start    <= mm_start_nxt;
         act_start   <= act_start_nxt;
         am_start    <= am_start_nxt;
         mm_k        <= mm_k_nxt;
         mm_n        <= mm_n_nxt;
         mm_src_sel  <= mm_src_sel_nxt;
         mm_dst_sel  <= mm_dst_sel_nxt;
         act_d       <= act_d_nxt;
         act_buf_sel <= act_buf_sel_nxt;
         am_size     <= am_size_nxt;
         am_buf_sel  <= am_buf_sel_nxt;
         result      <= result_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
      end
   end

`ifdef MLP_SEQ_WATCHDOG_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) error <= 1'b0;
      else         error <= error_nxt;
   end
`endif

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Directed bench for mlp_layer_sequencer; the watchdog scenario runs only
// when MLP_SEQ_WATCHDOG_EN is defined.
`timescale 1ns/1ps
module tb_mlp_layer_sequencer;

   localparam int DIM_W = 10;
   localparam int IDX_W = 4;
`ifdef MLP_SEQ_WATCHDOG_EN
   localparam int TB_TIMEOUT = 16;
`else
   localparam int TB_TIMEOUT = 1048576;
`endif

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic start = 1'b0, abort = 1'b0, in_ready = 1'b0;
   logic mm_done = 1'b0, act_done = 1'b0, am_done = 1'b0;
   logic [IDX_W-1:0] am_index = '0;
   logic mm_start, act_start, am_start, mm_dst_sel, act_buf_sel, am_buf_sel;
   logic busy, done, error;
   logic [DIM_W-1:0] mm_k, mm_n, act_d, am_size;
   logic [1:0] mm_src_sel;
   logic [IDX_W-1:0] result;
   logic [2:0] layer_idx;

   logic start2 = 1'b0, abort2 = 1'b0, in_ready2 = 1'b0;
   logic mm_done2 = 1'b0, act_done2 = 1'b0, am_done2 = 1'b0;
   logic [IDX_W-1:0] am_index2 = '0;
   logic mm_start2, act_start2, am_start2, mm_dst_sel2, act_buf_sel2, am_buf_sel2;
   logic busy2, done2, error2;
   logic [DIM_W-1:0] mm_k2, mm_n2, act_d2, am_size2;
   logic [1:0] mm_src_sel2;
   logic [IDX_W-1:0] result2;
   logic [2:0] layer_idx2;

   int vec = 0, errs = 0;

   always #5 clk = ~clk;

   mlp_layer_sequencer #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
      .clk(clk), .resetn(resetn), .start(start), .abort(abort), .in_ready(in_ready),
      .mm_start(mm_start), .mm_k(mm_k), .mm_n(mm_n), .mm_src_sel(mm_src_sel),
      .mm_dst_sel(mm_dst_sel), .mm_done(mm_done), .act_start(act_start), .act_d(act_d),
      .act_buf_sel(act_buf_sel), .act_done(act_done), .am_start(am_start),
      .am_size(am_size), .am_buf_sel(am_buf_sel), .am_done(am_done), .am_index(am_index),
      .busy(busy), .done(done), .result(result), .layer_idx(layer_idx), .error(error));

   mlp_layer_sequencer #(
      .NUM_LAYERS(2), .LAYER_DIMS({10'd3, 10'd20, 10'd30}), .RELU_MASK(2'b00)
   ) dut2 (
      .clk(clk), .resetn(resetn), .start(start2), .abort(abort2), .in_ready(in_ready2),
      .mm_start(mm_start2), .mm_k(mm_k2), .mm_n(mm_n2), .mm_src_sel(mm_src_sel2),
      .mm_dst_sel(mm_dst_sel2), .mm_done(mm_done2), .act_start(act_start2), .act_d(act_d2),
      .act_buf_sel(act_buf_sel2), .act_done(act_done2), .am_start(am_start2),
      .am_size(am_size2), .am_buf_sel(am_buf_sel2), .am_done(am_done2), .am_index(am_index2),
      .busy(busy2), .done(done2), .result(result2), .layer_idx(layer_idx2), .error(error2));

   // Engine models (done 3 cycles after each start) and activity logs for dut.
   int cyc = 0;
   int n_mm = 0, n_act = 0, n_done = 0, done_cyc = 0, am_done_cyc = 0;
   int mm_cnt = 0, act_cnt = 0, am_cnt = 0;
   bit mm_auto = 1'b1;
   int inj_mm_req = 0, inj_mm_ack = 0, inj_act_req = 0, inj_act_ack = 0;
   int src_log[16], dst_log[16], k_log[16], n_log[16], actd_log[16], actsel_log[16];
   int am_size_l = 0, am_sel_l = 0;
   int n_mm2 = 0, n_act2 = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      mm_done = 1'b0; act_done = 1'b0; am_done = 1'b0;
      if (mm_cnt > 0) begin mm_cnt--; if (mm_cnt == 0 && mm_auto) mm_done = 1'b1; end
      if (act_cnt > 0) begin act_cnt--; if (act_cnt == 0) act_done = 1'b1; end
      if (am_cnt > 0) begin
         am_cnt--;
         if (am_cnt == 0) begin am_done = 1'b1; am_done_cyc = cyc; end
      end
      if (inj_mm_ack != inj_mm_req) begin mm_done = 1'b1; inj_mm_ack++; end
      if (inj_act_ack != inj_act_req) begin act_done = 1'b1; inj_act_ack++; end
      if (mm_start) begin
         src_log[n_mm % 16] = int'(mm_src_sel); dst_log[n_mm % 16] = int'(mm_dst_sel);
         k_log[n_mm % 16] = int'(mm_k); n_log[n_mm % 16] = int'(mm_n);
         n_mm++; mm_cnt = 3;
      end
      if (act_start) begin
         actd_log[n_act % 16] = int'(act_d); actsel_log[n_act % 16] = int'(act_buf_sel);
         n_act++; act_cnt = 3;
      end
      if (am_start) begin am_size_l = int'(am_size); am_sel_l = int'(am_buf_sel); am_cnt = 3; end
      if (done) begin n_done++; done_cyc = cyc; end
      if (mm_start2) n_mm2++;
      if (act_start2) n_act2++;
   end

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (done) begin ok = 1'b1; break; end
      end
   endtask

   task automatic drive_run(input bit hold, input bit inj, output bit ok);
      @(negedge clk); start = 1'b1;
      @(negedge clk); if (!hold) start = 1'b0;
      vec++; if (busy !== 1'b1) begin errs++; $display("FAIL start_to_busy: got %0b want 1", busy); end
      if (inj) inj_mm_req++;
      repeat (4) @(negedge clk);
      in_ready = 1'b1;
      @(negedge clk); in_ready = 1'b0;
      vec++; if (mm_start !== 1'b1) begin errs++; $display("FAIL in_ready_to_mm_start: got %0b want 1", mm_start); end
      if (inj) inj_act_req++;
      wait_done(ok);
      start = 1'b0;
      vec++; if (!ok) begin errs++; $display("FAIL run_timeout: done not seen within 400 cycles"); end
      @(negedge clk);
   endtask

   task automatic check_layers(input string tag, input int base);
      int exp_src[4] = '{0, 1, 2, 1};
      int exp_dst[4] = '{0, 1, 0, 1};
      int exp_k[4]   = '{784, 64, 64, 32};
      int exp_n[4]   = '{64, 64, 32, 10};
      for (int i = 0; i < 4; i++) begin
         vec++;
         if (src_log[(base+i)%16] != exp_src[i] || dst_log[(base+i)%16] != exp_dst[i] ||
             k_log[(base+i)%16] != exp_k[i] || n_log[(base+i)%16] != exp_n[i]) begin
            errs++;
            $display("FAIL %s_layer%0d: got src=%0d dst=%0d k=%0d n=%0d want src=%0d dst=%0d k=%0d n=%0d",
                     tag, i, src_log[(base+i)%16], dst_log[(base+i)%16], k_log[(base+i)%16],
                     n_log[(base+i)%16], exp_src[i], exp_dst[i], exp_k[i], exp_n[i]);
         end
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      vec++; if (busy !== 1'b0 || done !== 1'b0 || mm_start !== 1'b0) begin
         errs++; $display("FAIL reset_ctrl: got busy=%0b done=%0b mm_start=%0b want 0 0 0", busy, done, mm_start); end
      resetn = 1'b1;
      @(negedge clk);
      vec++; if (result !== '0 || layer_idx !== 3'd0 || error !== 1'b0) begin
         errs++; $display("FAIL reset_state: got result=%0d layer=%0d error=%0b want 0 0 0", result, layer_idx, error); end
      vec++; if (mm_k !== '0 || am_size !== '0 || mm_src_sel !== 2'd0 || busy2 !== 1'b0) begin
         errs++; $display("FAIL reset_regs: got mm_k=%0d am_size=%0d src=%0d busy2=%0b want 0 0 0 0", mm_k, am_size, mm_src_sel, busy2); end
   endtask

   task automatic test_full_run;
      int base, abase, dbase;
      bit ok;
      base = n_mm; abase = n_act; dbase = n_done;
      am_index = 4'd7;
      drive_run(1'b0, 1'b0, ok);
      check_layers("full", base);
      vec++; if (n_mm - base != 4 || n_act - abase != 3) begin
         errs++; $display("FAIL full_counts: got mm=%0d act=%0d want 4 3", n_mm - base, n_act - abase); end
      vec++; if (actsel_log[abase%16] != 0 || actsel_log[(abase+1)%16] != 1 || actsel_log[(abase+2)%16] != 0) begin
         errs++; $display("FAIL full_act_sel: got %0d %0d %0d want 0 1 0", actsel_log[abase%16], actsel_log[(abase+1)%16], actsel_log[(abase+2)%16]); end
      vec++; if (actd_log[abase%16] != 64 || actd_log[(abase+1)%16] != 64 || actd_log[(abase+2)%16] != 32) begin
         errs++; $display("FAIL full_act_d: got %0d %0d %0d want 64 64 32", actd_log[abase%16], actd_log[(abase+1)%16], actd_log[(abase+2)%16]); end
      vec++; if (am_size_l != 10 || am_sel_l != 1) begin
         errs++; $display("FAIL full_argmax: got size=%0d sel=%0d want 10 1", am_size_l, am_sel_l); end
      vec++; if (result !== 4'd7 || n_done - dbase != 1 || busy !== 1'b0) begin
         errs++; $display("FAIL full_result: got result=%0d dones=%0d busy=%0b want 7 1 0", result, n_done - dbase, busy); end
      vec++; if (done_cyc - am_done_cyc != 1) begin
         errs++; $display("FAIL full_done_latency: got %0d want 1", done_cyc - am_done_cyc); end
   endtask

   task automatic test_two_layer;
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      vec++; if (busy2 !== 1'b1) begin errs++; $display("FAIL two_busy: got %0b want 1", busy2); end
      @(negedge clk); in_ready2 = 1'b1;
      @(negedge clk); in_ready2 = 1'b0;
      vec++; if (mm_start2 !== 1'b1 || mm_src_sel2 !== 2'd0 || mm_dst_sel2 !== 1'b0 || mm_k2 !== 10'd30 || mm_n2 !== 10'd20) begin
         errs++; $display("FAIL two_layer0: got start=%0b src=%0d dst=%0b k=%0d n=%0d want 1 0 0 30 20",
                          mm_start2, mm_src_sel2, mm_dst_sel2, mm_k2, mm_n2); end
      @(negedge clk); mm_done2 = 1'b1;
      @(negedge clk); mm_done2 = 1'b0;
      vec++; if (mm_start2 !== 1'b1 || mm_src_sel2 !== 2'd1 || mm_dst_sel2 !== 1'b1 || mm_k2 !== 10'd20 || mm_n2 !== 10'd3 || layer_idx2 !== 3'd1) begin
         errs++; $display("FAIL two_layer1: got start=%0b src=%0d dst=%0b k=%0d n=%0d layer=%0d want 1 1 1 20 3 1",
                          mm_start2, mm_src_sel2, mm_dst_sel2, mm_k2, mm_n2, layer_idx2); end
      @(negedge clk); mm_done2 = 1'b1;
      @(negedge clk); mm_done2 = 1'b0;
      vec++; if (am_start2 !== 1'b1 || am_buf_sel2 !== 1'b1 || am_size2 !== 10'd3) begin
         errs++; $display("FAIL two_argmax: got start=%0b sel=%0b size=%0d want 1 1 3", am_start2, am_buf_sel2, am_size2); end
      @(negedge clk); am_done2 = 1'b1; am_index2 = 4'd9;
      @(negedge clk); am_done2 = 1'b0;
      vec++; if (done2 !== 1'b1 || result2 !== 4'd9) begin
         errs++; $display("FAIL two_done: got done=%0b result=%0d want 1 9", done2, result2); end
      @(negedge clk);
      vec++; if (done2 !== 1'b0 || busy2 !== 1'b0 || n_mm2 != 2 || n_act2 != 0) begin
         errs++; $display("FAIL two_end: got done=%0b busy=%0b mm=%0d act=%0d want 0 0 2 0", done2, busy2, n_mm2, n_act2); end
   endtask

   task automatic test_abort;
      int base, dbase;
      bit hit, ok;
      am_index = 4'd5;
      dbase = n_done;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      in_ready = 1'b1;
      @(negedge clk); in_ready = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (act_start && layer_idx == 3'd1) begin hit = 1'b1; break; end
      end
      vec++; if (!hit) begin errs++; $display("FAIL abort_reach_act1: layer 1 ReLU not reached within 200 cycles"); end
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      vec++; if (busy !== 1'b0 || done !== 1'b0 || mm_start !== 1'b0 || act_start !== 1'b0 || result !== 4'd7) begin
         errs++; $display("FAIL abort_idle: got busy=%0b done=%0b mm_start=%0b act_start=%0b result=%0d want 0 0 0 0 7",
                          busy, done, mm_start, act_start, result); end
      repeat (6) @(negedge clk);
      vec++; if (busy !== 1'b0 || n_done != dbase || result !== 4'd7) begin
         errs++; $display("FAIL abort_quiet: got busy=%0b dones=%0d result=%0d want 0 0 7", busy, n_done - dbase, result); end
      base = n_mm;
      drive_run(1'b0, 1'b0, ok);
      check_layers("after_abort", base);
      vec++; if (result !== 4'd5 || n_done - dbase != 1) begin
         errs++; $display("FAIL after_abort_result: got result=%0d dones=%0d want 5 1", result, n_done - dbase); end
   endtask

   task automatic test_spurious;
      int base, abase, dbase;
      bit ok;
      base = n_mm; abase = n_act; dbase = n_done;
      am_index = 4'd3;
      drive_run(1'b0, 1'b1, ok);
      check_layers("spurious", base);
      vec++; if (n_mm - base != 4 || n_act - abase != 3 || n_done - dbase != 1 || result !== 4'd3) begin
         errs++; $display("FAIL spurious_counts: got mm=%0d act=%0d dones=%0d result=%0d want 4 3 1 3",
                          n_mm - base, n_act - abase, n_done - dbase, result); end
   endtask

   task automatic test_start_held;
      int base, dbase;
      bit ok;
      base = n_mm; dbase = n_done;
      am_index = 4'd11;
      drive_run(1'b1, 1'b0, ok);
      repeat (5) @(negedge clk);
      vec++; if (n_mm - base != 4 || n_done - dbase != 1 || busy !== 1'b0 || result !== 4'd11) begin
         errs++; $display("FAIL start_held: got mm=%0d dones=%0d busy=%0b result=%0d want 4 1 0 11",
                          n_mm - base, n_done - dbase, busy, result); end
   endtask

`ifdef MLP_SEQ_WATCHDOG_EN
   task automatic test_watchdog;
      int dbase;
      bit ok;
      mm_auto = 1'b0;
      dbase = n_done;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      in_ready = 1'b1;
      @(negedge clk); in_ready = 1'b0;
      repeat (16) @(negedge clk);
      vec++; if (busy !== 1'b1 || error !== 1'b0) begin
         errs++; $display("FAIL wd_before: got busy=%0b error=%0b want 1 0", busy, error); end
      @(negedge clk);
      vec++; if (busy !== 1'b0 || error !== 1'b1 || done !== 1'b0) begin
         errs++; $display("FAIL wd_expire: got busy=%0b error=%0b done=%0b want 0 1 0", busy, error, done); end
      mm_auto = 1'b1;
      repeat (3) @(negedge clk);
      vec++; if (error !== 1'b1 || n_done != dbase) begin
         errs++; $display("FAIL wd_sticky: got error=%0b dones=%0d want 1 0", error, n_done - dbase); end
      am_index = 4'd2;
      drive_run(1'b0, 1'b0, ok);
      vec++; if (error !== 1'b0 || result !== 4'd2) begin
         errs++; $display("FAIL wd_clear: got error=%0b result=%0d want 0 2", error, result); end
   endtask
`endif

   initial begin
      test_reset;
      test_full_run;
      test_two_layer;
      test_abort;
      test_spurious;
      test_start_held;
`ifdef MLP_SEQ_WATCHDOG_EN
      test_watchdog;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule

// File: doc/mlp_layer_sequencer.md
# mlp_layer_sequencer

- Parametrised controller that runs an N-layer fully-connected network on one shared matrix-multiply engine, one shared ReLU engine and one argmax unit.
- Layer intermediates ping-pong between two scratch buffers (A, B).
- Replaces the fixed four-layer FSM with a data-driven layer loop, per-layer ReLU enable, abort, and an optional stall watchdog.
- Sits between the UART input collector and the compute engines in the OCR top level.

## Interface
Parameters:
- NUM_LAYERS, 4, number of FC layers (1..8)
- DIM_W, 10, width of every dimension field
- LAYER_DIMS, {10'd10,10'd32,10'd64,10'd64,10'd784}, packed (NUM_LAYERS+1)*DIM_W
  - field 0 = input length
  - field i = output length of layer i
- RELU_MASK, 4'b0111, bit i-1 set = ReLU after layer i
- IDX_W, 4, argmax index width
- TIMEOUT_CYCLES, 1048576, watchdog limit per engine operation

Ports (reset resetn, asynchronous, active-low; clock clk):
- clk  in  1  clock
- resetn  in  1  async active-low reset
- start  in  1  run request; sampled in IDLE only
- abort  in  1  cancel run; honoured in any state
- in_ready  in  1  input vector fully loaded and valid
- mm_start  out  1  one-cycle engine start
- mm_k  out  DIM_W  current layer input length
- mm_n  out  DIM_W  current layer output length
- mm_src_sel  out  2  0 = input, 1 = buf A, 2 = buf B
- mm_dst_sel  out  1  0 = A, 1 = B
- mm_done  in  1  engine completion pulse
- act_start  out  1  one-cycle ReLU start; in place on act_buf_sel
- act_d  out  DIM_W  ReLU length
- act_buf_sel  out  1  0 = A, 1 = B
- act_done  in  1  ReLU completion pulse
- am_start  out  1  one-cycle argmax start
- am_size  out  DIM_W  argmax length
- am_buf_sel  out  1  buffer holding final logits
- am_done  in  1  argmax completion pulse
- am_index  in  IDX_W  argmax result
- busy  out  1  high outside IDLE
- done  out  1  one-cycle completion pulse
- result  out  IDX_W  last classification
- layer_idx  out  3  current layer, 0-based
- error  out  1  sticky watchdog flag

## Operation
- States: IDLE, WAIT_DATA, MM, ACT, ARGMAX, DONE.
- IDLE: start=1 → WAIT_DATA; error cleared; layer_idx ← 0.
- WAIT_DATA: in_ready=1 → MM, with mm_start pulsed on the transition edge.
- Layer i source and destination:
  - mm_src_sel = 0 for i=0, else 1 + (i-1)[0]
  - mm_dst_sel = i[0]
  - mm_k = field i; mm_n = field i+1
- MM, mm_done: if RELU_MASK[i] → ACT with act_start pulse (act_buf_sel = i[0], act_d = field i+1).
- MM, mm_done, no ReLU, and ACT done: i < NUM_LAYERS-1 → layer_idx+1, MM with mm_start; else → ARGMAX with am_start.
- ARGMAX: am_buf_sel = (NUM_LAYERS-1)[0]; am_size = field NUM_LAYERS.
- ARGMAX, am_done → DONE; result ← am_index on that edge.
- DONE: done=1 for one cycle → IDLE.
- Done inputs are ignored unless their matching state is active, and ignored in the cycle the matching start pulse is asserted.
- start while busy: ignored.
- abort: → IDLE next edge from any state; no done pulse; all start pulses deasserted; result unchanged.
- abort and start in the same IDLE cycle: abort wins; remain in IDLE.
- mm_k, mm_n and the selects are registered and stable for the whole operation.

## Timing
- All outputs are registered. Reset values: all 0, state IDLE.
- start → busy: 1 cycle.
- in_ready → mm_start: 1 cycle.
- Each *_done → next start pulse (or done): 1 cycle.
- Sequencer overhead per run: 2 + (layers + ReLUs + 1) cycles beyond engine time.
- result is valid from the cycle done is high until the next argmax completion.

## Configuration
- MLP_SEQ_WATCHDOG_EN defined:
  - Counter restarts on every start pulse (mm_start, act_start, am_start).
  - Counter reaching TIMEOUT_CYCLES in MM, ACT or ARGMAX → error ← 1 and state → IDLE; no done pulse.
  - error stays set until the next accepted start or reset.
- Undefined: no counter; error tied 0.

## Structure
- Shared package mlp_seq_pkg holds:
  - the state enum
  - source and destination select encodings
  - the default LAYER_DIMS and RELU_MASK constants
- Sub-module mlp_seq_watchdog: counter, clear, expire; instantiated only under the macro.

## Test plan
- Default params, start, in_ready 5 cycles later, engine models return done after 3 cycles → mm_src_sel sequence 0,1,2,1, dst 0,1,0,1, three act_start pulses, am_size=10, am_index=7 → done pulse and result=7.
- NUM_LAYERS=2, RELU_MASK=2'b00 → no act_start, mm_start twice, am_buf_sel=1.
- abort asserted in ACT of layer 1 → IDLE next cycle, no done, result keeps prior value, new start runs cleanly.
- Spurious mm_done in WAIT_DATA and act_done in MM → ignored, sequence unchanged.
- start held high through the run → exactly one run, no restart until IDLE.
- With MLP_SEQ_WATCHDOG_EN and TIMEOUT_CYCLES=16, mm_done withheld → error=1 after 16 cycles, busy=0, no done; next start clears error.
